// File: rtl/fish_pkg.sv
// Shared types and constants for the fish bounding-box tracker.
package fish_pkg;

  localparam int COORD_W = 16;
  typedef logic [COORD_W-1:0] coord_t;
  localparam coord_t COORD_MAX = '1;

  localparam int AREA_W = 20;
  typedef logic [AREA_W-1:0] area_t;
  localparam area_t AREA_MAX = '1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  function automatic coord_t coord_min(input coord_t a, input coord_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic coord_t coord_max(input coord_t a, input coord_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fish_bbox_tracker_if.sv
// Pixel-mask stream in, bounding-box result out.
interface fish_bbox_tracker_if;
  import fish_pkg::*;

  logic   pix_valid;
  logic   pix_sop;
  logic   pix_eop;
  logic   pix_fg;
  coord_t box_xn;
  coord_t box_xk;
  coord_t box_yn;
  coord_t box_yk;
  logic   box_valid;
  logic   frame_done;
  logic   frame_err;

  modport master (
    output pix_valid, pix_sop, pix_eop, pix_fg,
    input  box_xn, box_xk, box_yn, box_yk, box_valid, frame_done, frame_err
  );

  modport slave (
    input  pix_valid, pix_sop, pix_eop, pix_fg,
    output box_xn, box_xk, box_yn, box_yk, box_valid, frame_done, frame_err
  );

endinterface

// File: rtl/fish_pix_xy_counter.sv
// Raster x/y counter: x_o/y_o are the coordinates of the beat presented this
// cycle (0,0 on sop); the registers hold the coordinates of the following beat.
module fish_pix_xy_counter
  import fish_pkg::*;
#(
  parameter int IMG_W = 640
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   beat_i,
  input  logic   sop_i,
  output coord_t x_o,
  output coord_t y_o
);

  localparam coord_t X_LAST = coord_t'(IMG_W - 1);
  localparam coord_t ONE    = coord_t'(1);

  coord_t x_q, y_q, x_cur, y_cur, x_d, y_d;

  always_comb begin
    x_cur = sop_i ? '0 : x_q;
    y_cur = sop_i ? '0 : y_q;
    x_d   = x_q;
    y_d   = y_q;
    if (beat_i) begin
      if (x_cur == X_LAST) begin
        x_d = '0;
        y_d = (y_cur == COORD_MAX) ? y_cur : y_cur + ONE;
      end else begin
        x_d = x_cur + ONE;
        y_d = y_cur;
      end
    end
  end

  assign x_o = x_cur;
  assign y_o = y_cur;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/fish_bbox_tracker.sv
// Streaming min/max X/Y tracker over a binary foreground mask, latched per frame.
// Optional minimum-area qualification via FISH_BBOX_AREA_FILTER_EN.
module fish_bbox_tracker
  import fish_pkg::*;
#(
  parameter int IMG_W    = 640,
  parameter int MIN_AREA = 16
) (
  input logic               clk,
  input logic               reset_n,
  fish_bbox_tracker_if.slave bus
);

  state_e state_q;
  coord_t x, y;
  coord_t xmin_q, xmax_q, ymin_q, ymax_q;
  coord_t xmin_b, xmax_b, ymin_b, ymax_b;
  coord_t xmin_d, xmax_d, ymin_d, ymax_d;
  logic   seen_q, seen_b, seen_d;
  coord_t box_xn_q, box_xk_q, box_yn_q, box_yk_q;
  logic   box_valid_q, frame_done_q, frame_err_q;
  logic   beat, sop_b, eop_b, accept, area_ok, box_ok;

  assign beat   = bus.pix_valid;
  assign sop_b  = beat & bus.pix_sop;
  assign eop_b  = beat & bus.pix_eop;
  // Outside a frame only a sop beat is taken; everything else is dropped.
  assign accept = sop_b | (beat & (state_q == ACTIVE));

  fish_pix_xy_counter #(.IMG_W(IMG_W)) u_xy (
    .clk     (clk),
    .reset_n (reset_n),
    .beat_i  (beat),
    .sop_i   (sop_b),
    .x_o     (x),
    .y_o     (y)
  );

  always_comb begin
    xmin_b = sop_b ? COORD_MAX : xmin_q;
    xmax_b = sop_b ? '0 : xmax_q;
    ymin_b = sop_b ? COORD_MAX : ymin_q;
    ymax_b = sop_b ? '0 : ymax_q;
    seen_b = sop_b ? 1'b0 : seen_q;
    xmin_d = xmin_b;
    xmax_d = xmax_b;
    ymin_d = ymin_b;
    ymax_d = ymax_b;
    seen_d = seen_b;
    if (bus.pix_fg) begin
      xmin_d = coord_min(xmin_b, x);
      xmax_d = coord_max(xmax_b, x);
      ymin_d = coord_min(ymin_b, y);
      ymax_d = coord_max(ymax_b, y);
      seen_d = 1'b1;
    end
  end

`ifdef FISH_BBOX_AREA_FILTER_EN
  area_t area_q, area_b, area_d;

  always_comb begin
    area_b = sop_b ? '0 : area_q;
    area_d = area_b;
    if (bus.pix_fg && (area_b != AREA_MAX))
      area_d = area_b + area_t'(1);
  end

  assign area_ok = (area_d >= area_t'(MIN_AREA));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      area_q <= '0;
    else if (accept)
      area_q <= area_d;
  end
`else
  // Without the filter any seen pixel qualifies; MIN_AREA has no effect.
  assign area_ok = (MIN_AREA >= 0);
`endif

  assign box_ok = seen_d & area_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      xmin_q       <= COORD_MAX;
      xmax_q       <= '0;
      ymin_q       <= COORD_MAX;
      ymax_q       <= '0;
      seen_q       <= 1'b0;
      box_xn_q     <= '0;
      box_xk_q     <= '0;
      box_yn_q     <= '0;
      box_yk_q     <= '0;
      box_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_done_q <= accept & eop_b;
      frame_err_q  <= sop_b & (state_q == ACTIVE);
      if (accept) begin
        xmin_q <= xmin_d;
        xmax_q <= xmax_d;
        ymin_q <= ymin_d;
        ymax_q <= ymax_d;
        seen_q <= seen_d;
        if (eop_b) begin
          state_q     <= IDLE;
          box_xn_q    <= box_ok ? xmin_d : '0;
          box_xk_q    <= box_ok ? xmax_d : '0;
          box_yn_q    <= box_ok ? ymin_d : '0;
          box_yk_q    <= box_ok ? ymax_d : '0;
          box_valid_q <= box_ok;
        end else begin
          state_q <= ACTIVE;
        end
      end
    end
  end

  assign bus.box_xn     = box_xn_q;
  assign bus.box_xk     = box_xk_q;
  assign bus.box_yn     = box_yn_q;
  assign bus.box_yk     = box_yk_q;
  assign bus.box_valid  = box_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_fish_bbox_tracker.sv
// Bench for fish_bbox_tracker: directed and random frames against a
// pixel-list model that derives coordinates from each beat's index in the frame.
module tb_fish_bbox_tracker;
  import fish_pkg::*;

  localparam int W     = 8;
  localparam int MIN_A = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fish_bbox_tracker_if bus();

  fish_bbox_tracker #(.IMG_W(W), .MIN_AREA(MIN_A)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: open frame and the fg flag of every accepted beat.
  bit     open_m = 1'b0;
  bit     fgq[$];
  coord_t exp_xn = '0, exp_xk = '0, exp_yn = '0, exp_yk = '0;
  bit     exp_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input bit exp_done, input bit exp_err);
    chk("frame_done", bus.frame_done, exp_done);
    chk("frame_err", bus.frame_err, exp_err);
    chk("box_xn", bus.box_xn, exp_xn);
    chk("box_xk", bus.box_xk, exp_xk);
    chk("box_yn", bus.box_yn, exp_yn);
    chk("box_yk", bus.box_yk, exp_yk);
    chk("box_valid", bus.box_valid, exp_valid);
  endtask

  task automatic model_close();
    int     n = 0;
    bit     ok;
    coord_t xn = COORD_MAX, xk = '0, yn = COORD_MAX, yk = '0;
    for (int i = 0; i < fgq.size(); i++) begin
      if (fgq[i]) begin
        int xi = i % W;
        int yi = i / W;
        if (yi > 65535) yi = 65535;
        if (coord_t'(xi) < xn) xn = coord_t'(xi);
        if (coord_t'(xi) > xk) xk = coord_t'(xi);
        if (coord_t'(yi) < yn) yn = coord_t'(yi);
        if (coord_t'(yi) > yk) yk = coord_t'(yi);
        n++;
      end
    end
    ok = (n > 0);
`ifdef FISH_BBOX_AREA_FILTER_EN
    ok = ok && (n >= MIN_A);
`endif
    exp_valid = ok;
    exp_xn = ok ? xn : '0;
    exp_xk = ok ? xk : '0;
    exp_yn = ok ? yn : '0;
    exp_yk = ok ? yk : '0;
  endtask

  task automatic beat(input bit v, input bit s, input bit e, input bit f);
    bit exp_done = 1'b0;
    bit exp_err = 1'b0;
    bus.pix_valid = v;
    bus.pix_sop   = s;
    bus.pix_eop   = e;
    bus.pix_fg    = f;
    if (v) begin
      if (s) begin
        exp_err = open_m;
        fgq.delete();
        open_m = 1'b1;
      end
      if (open_m) begin
        fgq.push_back(f);
        if (e) begin
          model_close();
          exp_done = 1'b1;
          open_m = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk_all(exp_done, exp_err);
  endtask

  // gap_mode: 0 = gapless, 1 = idle cycle before every beat, 2 = random idles
  task automatic send_frame(input int len, input logic [63:0] mask, input int gap_mode,
                            input bit do_eop);
    for (int i = 0; i < len; i++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0))
        beat(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      beat(1'b1, i == 0, do_eop && (i == len - 1), mask[i]);
    end
  endtask

  initial begin
    logic [63:0] m;
    bus.pix_valid = 1'b0;
    bus.pix_sop   = 1'b0;
    bus.pix_eop   = 1'b0;
    bus.pix_fg    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_all(1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Object at (2,1),(5,1),(3,2) in an 8x4 frame
    send_frame(32, (64'h1 << 10) | (64'h1 << 13) | (64'h1 << 19), 0, 1'b1);
    // All background
    send_frame(32, 64'h0, 0, 1'b1);
    // Foreground only on the eop pixel (7,3)
    send_frame(32, 64'h1 << 31, 0, 1'b1);
    // Restart at beat 10 of a foreground-heavy frame
    send_frame(10, 64'h3FF, 0, 1'b0);
    send_frame(32, (64'h1 << 9) | (64'h1 << 20), 0, 1'b1);
    // Stray beats while idle, then the first frame again with alternating gaps
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, 1'($urandom), 1'b1);
    send_frame(32, (64'h1 << 10) | (64'h1 << 13) | (64'h1 << 19), 1, 1'b1);
    // Area threshold: 3, 4 and 1 foreground pixels
    send_frame(32, 64'hE, 0, 1'b1);
    send_frame(32, 64'h1E, 0, 1'b1);
    send_frame(32, 64'h100, 0, 1'b1);
    // Single-pixel frames, idle and aborting an open frame
    send_frame(1, 64'h1, 0, 1'b1);
    send_frame(5, 64'h1F, 0, 1'b0);
    send_frame(1, 64'h0, 0, 1'b1);

    for (int f = 0; f < 60; f++) begin
      m = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: m = '0;
        1: m = m & {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        2: m = m & {$urandom, $urandom};
        default: ;
      endcase
      send_frame($urandom_range(1, 48), m, $urandom_range(0, 2), $urandom_range(0, 7) != 0);
    end

    // Reset in the middle of a frame drops it and clears the outputs
    send_frame(32, 64'hFFFF_FFFF, 0, 1'b1);
    send_frame(12, 64'hF0F, 0, 1'b0);
    bus.pix_valid = 1'b0;
    reset_n = 1'b0;
    open_m = 1'b0;
    fgq.delete();
    exp_xn = '0; exp_xk = '0; exp_yn = '0; exp_yk = '0; exp_valid = 1'b0;
    #2;
    chk_all(1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    send_frame(32, (64'h1 << 12) | (64'h1 << 27), 0, 1'b1);
    beat(1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
